// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST wrapper: widths, LFSR/MISR taps,
// controller state encoding and the feedback helper.
package bist_pkg;

    localparam int TPG_W = 8;
    localparam int SIG_W = 8;
    localparam int CUT_W = 4;

    // Feedback taps q[7], q[5], q[4], q[3]  (x^8 + x^6 + x^5 + x^4 + 1)
    localparam logic [TPG_W-1:0] LFSR_POLY_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_COMPARE,
        ST_DONE
    } bist_state_e;

    function automatic logic lfsr_fb(input logic [TPG_W-1:0] v);
        return ^(v & LFSR_POLY_TAPS);
    endfunction

endpackage

// File: rtl/bist_cut.sv
// Small sequential circuit-under-test: 4-bit state, 2-bit input and output.
// Output is combinational from current state and input.
module bist_cut
    import bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [1:0] x,
    output logic [1:0] y
);

    logic [CUT_W-1:0] s_q, s_d;

    always_comb begin
        s_d = s_q;
        if (clear) begin
            s_d = '0;
        end else if (en) begin
            s_d = {s_q[CUT_W-2:0], x[0] ^ x[1]} ^ {{(CUT_W-1){1'b0}}, s_q[CUT_W-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign y = {s_q[CUT_W-1] ^ x[0], s_q[0] & x[1]};

endmodule

// File: rtl/bist_top.sv
// BIST wrapper: LFSR pattern generator drives the CUT, a MISR compacts its
// responses, and the controller compares the signature against GOLDEN_SIG.
module bist_top
    import bist_pkg::*;
#(
    parameter int unsigned      N_PATTERNS = 16,
    parameter logic [TPG_W-1:0] LFSR_SEED  = 8'h01,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 8'h00
) (
    input  logic clock,
    input  logic reset,
    input  logic bist_start,
    output logic bist_end,
    output logic pass_nfail
);

    localparam logic [7:0] LAST_CNT = 8'(N_PATTERNS - 1);

    // Asynchronous assert, synchronised deassert
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    bist_state_e      state_q, state_d;
    logic [TPG_W-1:0] lfsr_q, lfsr_d;
    logic [SIG_W-1:0] misr_q, misr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             end_q, end_d;
    logic             pass_q, pass_d;
    logic             cut_clear, cut_en;
    logic [1:0]       cut_x, cut_y;

    assign cut_x = lfsr_q[1:0];

    bist_cut u_cut (
        .clk   (clock),
        .rst_n (rst_n),
        .clear (cut_clear),
        .en    (cut_en),
        .x     (cut_x),
        .y     (cut_y)
    );

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        cut_clear = 1'b0;
        cut_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bist_start) begin
                    state_d = ST_INIT;
                    pass_d  = 1'b0;
                end
            end
            ST_INIT: begin
                lfsr_d    = LFSR_SEED;
                misr_d    = '0;
                cnt_d     = '0;
                cut_clear = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                cut_en = 1'b1;
                misr_d = {misr_q[SIG_W-2:0], lfsr_fb(misr_q)} ^ {{(SIG_W-2){1'b0}}, cut_y};
                lfsr_d = {lfsr_q[TPG_W-2:0], lfsr_fb(lfsr_q)};
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                pass_d  = (misr_q == GOLDEN_SIG);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bist_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered from next state so bist_end is high exactly while in DONE
        end_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            cnt_q   <= '0;
            end_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            pass_q  <= pass_d;
        end
    end

    assign bist_end   = end_q;
    assign pass_nfail = pass_q;

endmodule

// File: tb/tb_bist_top.sv
// Bench for bist_top: two instances share stimulus, one with the model golden
// signature (must pass) and one with a corrupted golden value (must fail).
module tb_bist_top;

    localparam int NP = 8;
    localparam logic [7:0] SEED = 8'h01;

    function automatic logic [7:0] model_sig(input int n, input logic [7:0] seed);
        logic [7:0] l, m;
        logic [3:0] s;
        logic [1:0] x, y;
        l = seed;
        m = 8'h00;
        s = 4'h0;
        for (int i = 0; i < n; i++) begin
            x = l[1:0];
            y = {s[3] ^ x[0], s[0] & x[1]};
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {6'b0, y};
            s = {s[2:0], x[0] ^ x[1]} ^ {3'b000, s[3]};
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = model_sig(NP, SEED);

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic bist_start = 1'b0;
    logic end_a, pass_a, end_b, pass_b;

    always #5 clock = ~clock;

    bist_top #(.N_PATTERNS(NP), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)) dut_pass (
        .clock      (clock),
        .reset      (reset),
        .bist_start (bist_start),
        .bist_end   (end_a),
        .pass_nfail (pass_a)
    );

    bist_top #(.N_PATTERNS(NP), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD ^ 8'h01)) dut_fail (
        .clock      (clock),
        .reset      (reset),
        .bist_start (bist_start),
        .bist_end   (end_b),
        .pass_nfail (pass_b)
    );

    typedef struct {
        int   lat;
        logic pa;
        logic pb;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise start just after an edge; the next edge is the start sample E0.
    task automatic start_run(input bit keep);
        bist_start = 1'b1;
        sb.push_back('{NP + 2, 1'b1, 1'b0});
        tick();
        if (!keep) bist_start = 1'b0;
    endtask

    // Called just after E0 (or at an unknown offset when exact=0).
    task automatic await_done(input string tag, input bit exact);
        exp_t e;
        int cnt;
        e = sb.pop_front();
        cnt = 0;
        while (end_a !== 1'b1 && cnt <= e.lat + 8) begin
            if (exact && cnt >= 2) check({tag, "_pass_clr"}, 32'(pass_a), 32'(1'b0));
            tick();
            cnt++;
        end
        if (exact) check({tag, "_latency"}, 32'(cnt), 32'(e.lat));
        check({tag, "_end_a"}, 32'(end_a), 32'(1'b1));
        check({tag, "_end_b"}, 32'(end_b), 32'(1'b1));
        check({tag, "_pass_a"}, 32'(pass_a), 32'(e.pa));
        check({tag, "_pass_b"}, 32'(pass_b), 32'(e.pb));
    endtask

    initial begin
        // Reset held with start high
        reset = 1'b0;
        bist_start = 1'b1;
        #50;
        check("rst_end_a", 32'(end_a), 32'(1'b0));
        check("rst_pass_a", 32'(pass_a), 32'(1'b0));
        #49;
        check("rst_end_b", 32'(end_b), 32'(1'b0));
        check("rst_pass_b", 32'(pass_b), 32'(1'b0));
        #1;
        reset = 1'b1;
        sb.push_back('{NP + 2, 1'b1, 1'b0});
        await_done("post_reset", 1'b0);

        // DONE holds while start stays high, exits one edge after start low
        repeat (3) tick();
        check("done_hold", 32'(end_a), 32'(1'b1));
        bist_start = 1'b0;
        tick();
        check("done_exit", 32'(end_a), 32'(1'b0));
        check("idle_keep_pass_a", 32'(pass_a), 32'(1'b1));
        check("idle_keep_pass_b", 32'(pass_b), 32'(1'b0));
        tick();

        // Timed run, then a back-to-back run with the same signature
        start_run(1'b1);
        await_done("run1", 1'b1);
        bist_start = 1'b0;
        tick();
        start_run(1'b1);
        await_done("run2", 1'b1);
        bist_start = 1'b0;
        tick();

        // One-cycle start pulse
        start_run(1'b0);
        await_done("glitch", 1'b1);
        tick();
        check("glitch_end_pulse", 32'(end_a), 32'(1'b0));
        repeat (3) tick();
        check("glitch_idle_pass_a", 32'(pass_a), 32'(1'b1));
        check("glitch_idle_end_a", 32'(end_a), 32'(1'b0));

        // Reset in RUN cycle 3, then restart
        start_run(1'b1);
        void'(sb.pop_front());
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_end_a", 32'(end_a), 32'(1'b0));
        check("midrst_pass_a", 32'(pass_a), 32'(1'b0));
        check("midrst_end_b", 32'(end_b), 32'(1'b0));
        check("midrst_pass_b", 32'(pass_b), 32'(1'b0));
        #20;
        reset = 1'b1;
        sb.push_back('{NP + 2, 1'b1, 1'b0});
        await_done("restart", 1'b0);
        bist_start = 1'b0;
        tick();
        check("restart_exit", 32'(end_a), 32'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bist_top.md
# bist_top

Self-contained built-in self-test (BIST) wrapper.
- On request, it drives a small sequential circuit-under-test (CUT) with pseudo-random patterns from an LFSR.
- It compacts the CUT responses into a MISR signature and compares that signature with a golden value.
- It reports completion and pass/fail on two output flags.
- It is the top of the BIST subsystem; a test controller or pin-level harness drives `bist_start` and samples `bist_end`/`pass_nfail`.

## Interface
Parameters:
- `N_PATTERNS`, default 16: number of RUN cycles (patterns applied), range 1..255.
- `LFSR_SEED`, default 8'h01: TPG seed; must be non-zero.
- `GOLDEN_SIG`, default 8'h00: expected MISR signature. Integration overrides it with the golden-model value.

Ports:
- `clock`: input, 1 bit. Single clock, rising-edge.
- `reset`: input, 1 bit. Asynchronous, active-low.
- `bist_start`: input, 1 bit. Test request, level-sensitive.
- `bist_end`: output, 1 bit. High while the test is complete.
- `pass_nfail`: output, 1 bit. 1 = signature matched, 0 = fail or no result yet.

## Operation
Controller FSM states: IDLE, INIT, RUN, COMPARE, DONE.

- **Reset** (`reset`=0, asynchronous): state=IDLE, `bist_end`=0, `pass_nfail`=0, LFSR=`LFSR_SEED`, MISR=0, CUT state=0, counter=0.
- **IDLE**
  - `bist_end`=0.
  - `pass_nfail` holds the previous result (0 after reset).
  - Transition to INIT when `bist_start`=1 is sampled.
- **INIT** (1 cycle): load LFSR=`LFSR_SEED`, clear MISR, CUT state and counter; `pass_nfail`:=0. Then go to RUN.
- **RUN**, each cycle:
  - CUT input x[1:0] = LFSR[1:0].
  - CUT state s[3:0] updates: s <= {s[2:0], x[0]^x[1]} ^ {3'b000, s[3]}.
  - CUT output y[1:0] = {s[3]^x[0], s[0]&x[1]}, combinational from current s and x.
  - MISR absorbs y.
  - LFSR steps.
  - Counter increments; after the `N_PATTERNS`-th RUN cycle, go to COMPARE.
- **LFSR**: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shift left; new bit0 = q[7]^q[5]^q[4]^q[3].
- **MISR**: 8-bit, same feedback as the LFSR. m <= {m[6:0], fb} ^ {6'b0, y}, where fb is the same XOR taps applied to m.
- **COMPARE** (1 cycle): register result = (MISR == `GOLDEN_SIG`). Then go to DONE.
- **DONE**
  - `bist_end`=1, `pass_nfail`=result.
  - Stay while `bist_start`=1.
  - On `bist_start`=0, go to IDLE; `bist_end` falls, `pass_nfail` keeps its value.
- `bist_start` changes during INIT, RUN or COMPARE are ignored.
- A new test needs `bist_start` to return to 0 (seen in DONE) and then rise again.

## Timing
- All outputs are registered; no combinational path from `bist_start` to the outputs.
- Sample edge E0 is the rising edge where IDLE sees `bist_start`=1.
- The state is INIT after E0, RUN after E0+1, and COMPARE after E0+1+`N_PATTERNS`.
- `bist_end` rises after edge E0+`N_PATTERNS`+2, i.e. `N_PATTERNS`+2 cycles of latency.
- `pass_nfail` is valid in the same cycle that `bist_end` rises.
- `bist_end` falls one edge after `bist_start`=0 is sampled in DONE.
- Reset asserted mid-test aborts immediately to the reset values, with no result retained. Deassertion is synchronised internally (2-flop reset synchroniser).
- Counter width: 8 bits. No wrap can occur because `N_PATTERNS` ≤ 255.

## Structure
- Package `bist_pkg` holds:
  - the FSM state enum;
  - `LFSR_POLY_TAPS` constant;
  - widths `TPG_W`=8, `SIG_W`=8, `CUT_W`=4.
- Natural sub-module: `bist_cut`, the 4-bit CUT FSM with 2-bit input/output, reset and clear inputs.
- The LFSR, MISR and controller stay inline in `bist_top`.

## Test plan
- **Reset:** hold `reset`=0 for 100 ns with `bist_start`=1, then release -> during reset `bist_end`=0 and `pass_nfail`=0; the test starts on the first sampled edge after reset release.
- **Pass run:** `N_PATTERNS`=8, `GOLDEN_SIG` = model value, `bist_start` held at 1 -> `bist_end` rises exactly 10 cycles after the start sample with `pass_nfail`=1, and stays until `bist_start`=0.
- **Fail run:** same stimulus with `GOLDEN_SIG` = model value ^ 8'h01 -> `bist_end`=1 with `pass_nfail`=0.
- **Start glitch:** pulse `bist_start` high for 1 cycle, then low -> the run completes; `bist_end` pulses for 1 cycle and `pass_nfail` holds the result afterwards in IDLE.
- **Mid-test reset:** assert `reset`=0 at RUN cycle 3 -> outputs are 0 immediately; restarting gives the same signature as a clean run.
- **Back-to-back runs:** two consecutive runs -> identical signatures (LFSR reseeded in INIT); `pass_nfail` is 0 during the second run until its DONE.
